// File: rtl/exu_muldiv.sv
// Execute stage for RV32M: an iterative radix-2 multiply/divide unit that stalls E,
// plus the EX/MEM pipeline register. Base-ALU results pass through in one cycle.
module exu_muldiv #(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0,
    parameter int CNT_W    = $clog2(XLEN+1)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ValidE,
    input  logic            MulDivE,
    input  logic [2:0]      MulDivOpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic            RegWriteE,
    input  logic [4:0]      rdE,
    input  logic            FlushE,
    output logic            StallE,
    output logic            ValidM,
    output logic            RegWriteM,
    output logic [4:0]      rdM,
    output logic [XLEN-1:0] ResultM
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, nextState;

    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  magA, magB, accHi, accLo;
    logic [2:0]       opM;
    logic             negQ, negR, special;

    logic            isDivE, aSignedE, bSignedE, negAE, negBE;
    logic            fastOpE, startE, divZeroE, ovfE;
    logic [XLEN-1:0] absAE, absBE, fastResult;

    always_comb begin
        isDivE   = MulDivOpE[2];
        aSignedE = (MulDivOpE == 3'd1) | (MulDivOpE == 3'd2) |
                   (MulDivOpE == 3'd4) | (MulDivOpE == 3'd6);
        bSignedE = (MulDivOpE == 3'd1) | (MulDivOpE == 3'd4) | (MulDivOpE == 3'd6);
        negAE    = aSignedE & SrcAE[XLEN-1];
        negBE    = bSignedE & SrcBE[XLEN-1];
        absAE    = negAE ? -SrcAE : SrcAE;
        absBE    = negBE ? -SrcBE : SrcBE;
        fastOpE  = FAST_MUL & ~isDivE;
        startE   = ValidE & MulDivE & ~FlushE & ~fastOpE;
        divZeroE = isDivE & (SrcBE == '0);
        ovfE     = isDivE & ~MulDivOpE[0] & (SrcAE == MIN_INT) & (SrcBE == '1);
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        StallE    = 1'b0;
        case (state)
            IDLE: if (startE) begin
                StallE    = 1'b1;
                nextState = (divZeroE | ovfE) ? DONE : BUSY;
            end
            BUSY: if (FlushE) begin
                nextState = IDLE;
            end else begin
                StallE = 1'b1;
                if (cnt == CNT_W'(1)) nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (RST) begin
            StallE    = 1'b0;
            nextState = IDLE;
        end
    end

    // Multiply keeps {accHi,accLo} as the shifting product; divide keeps remainder:quotient.
    logic [XLEN:0] mulSum, divShift, divDiff;
    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, magA} : '0);
        divShift = {accHi, accLo[XLEN-1]};
        divDiff  = divShift - {1'b0, magB};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt     <= '0;
            magA    <= '0;
            magB    <= '0;
            accHi   <= '0;
            accLo   <= '0;
            opM     <= '0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            special <= 1'b0;
        end else begin
            case (state)
                IDLE: if (startE) begin
                    opM     <= MulDivOpE;
                    magA    <= absAE;
                    magB    <= absBE;
                    negQ    <= negAE ^ negBE;
                    negR    <= negAE;
                    special <= divZeroE | ovfE;
                    cnt     <= CNT_W'(XLEN);
                    if (divZeroE) begin
                        accHi <= SrcAE;
                        accLo <= '1;
                    end else if (ovfE) begin
                        accHi <= '0;
                        accLo <= MIN_INT;
                    end else begin
                        accHi <= '0;
                        accLo <= isDivE ? absAE : absBE;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (!opM[2]) begin
                        accHi <= mulSum[XLEN:1];
                        accLo <= {mulSum[0], accLo[XLEN-1:1]};
                    end else if (!divDiff[XLEN]) begin
                        accHi <= divDiff[XLEN-1:0];
                        accLo <= {accLo[XLEN-2:0], 1'b1};
                    end else begin
                        accHi <= divShift[XLEN-1:0];
                        accLo <= {accLo[XLEN-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    // Special-case results are preloaded already signed, so they skip correction.
    logic [2*XLEN-1:0] prodFull, prodFix;
    logic [XLEN-1:0]   qFix, rFix, mdResult;
    always_comb begin
        prodFull = {accHi, accLo};
        prodFix  = negQ ? -prodFull : prodFull;
        qFix     = (negQ & ~special) ? -accLo : accLo;
        rFix     = (negR & ~special) ? -accHi : accHi;
        case (opM)
            3'd0:       mdResult = prodFix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       mdResult = prodFix[2*XLEN-1:XLEN];
            3'd4, 3'd5: mdResult = qFix;
            default:    mdResult = rFix;
        endcase
    end

    generate
        if (FAST_MUL) begin : gFast
            logic [2*XLEN-1:0] extA, extB, prod;
            assign extA       = {{XLEN{negAE}}, SrcAE};
            assign extB       = {{XLEN{negBE}}, SrcBE};
            assign prod       = extA * extB;
            assign fastResult = (MulDivOpE == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin : gIter
            assign fastResult = '0;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            ValidM    <= 1'b0;
            RegWriteM <= 1'b0;
            rdM       <= '0;
            ResultM   <= '0;
        end else if (!StallE) begin
            ValidM    <= ValidE & ~FlushE;
            RegWriteM <= RegWriteE & ~FlushE;
            rdM       <= rdE;
            if (state == DONE)          ResultM <= mdResult;
            else if (MulDivE & fastOpE) ResultM <= fastResult;
            else                        ResultM <= ALUResultE;
        end else begin
            ValidM    <= 1'b0;
            RegWriteM <= 1'b0;
        end
    end

endmodule
